seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.

---
 rtl/seg7_pkg.sv | 11 +
 rtl/seg7_scan_driver_if.sv | 25 ++
 rtl/seg7_decode.sv | 9 +
 rtl/seg7_scan_driver.sv | 131 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low abcdefg glyphs for hex digits.
package seg7_pkg;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_CODE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display data request side plus the scanned pin outputs of the driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_en;
    logic                    load;
    logic [NUM_DIGITS-1:0]   anode;
    logic [6:0]              seg;
    logic                    dp;
    logic                    pending;
    logic                    frame_tick;

    modport master (
        output data_in, dp_in, blank_in, lz_en, load,
        input  anode, seg, dp, pending, frame_tick
    );

    modport slave (
        input  data_in, dp_in, blank_in, lz_en, load,
        output anode, seg, dp, pending, frame_tick
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low abcdefg segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_CODE[nibble];
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned double buffering,
// per-digit blanking, decimal points and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic                clk,
    input  logic                reset,
    seg7_scan_driver_if.slave   bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]      sh_data_q, sh_data_d, act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]           sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]           sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic                            pending_q, pending_d;
    logic                            frame_tick_q, frame_tick_d;
    logic [NUM_DIGITS-1:0]           anode_q, anode_d;
    logic [6:0]                      seg_q, seg_d;
    logic                            dp_q, dp_d;

    logic [NUM_DIGITS-1:0][3:0]      din;
    logic                            term, wrap, zero_run, dark;
    logic [NUM_DIGITS-1:0]           lz_dark;
    logic [6:0]                      dec_seg;

    assign din = bus.data_in;

    seg7_decode u_dec (
        .nibble (act_data_q[idx_q]),
        .seg    (dec_seg)
    );

    always_comb begin
        term  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        wrap  = term && (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d = term ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (term) idx_d = wrap ? '0 : idx_q + 1'b1;

        sh_data_d   = sh_data_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        pending_d   = pending_q;

        if (bus.load) begin
            sh_data_d  = din;
            sh_dp_d    = bus.dp_in;
            sh_blank_d = bus.blank_in;
            pending_d  = 1'b1;
        end
        // A load landing on the wrap bypasses the shadow so it is not held back a whole frame.
        if (wrap) begin
            if (bus.load) begin
                act_data_d  = din;
                act_dp_d    = bus.dp_in;
                act_blank_d = bus.blank_in;
            end else if (pending_q) begin
                act_data_d  = sh_data_q;
                act_dp_d    = sh_dp_q;
                act_blank_d = sh_blank_q;
            end
            pending_d = 1'b0;
        end
        frame_tick_d = wrap;

        // Scan from the most significant digit down; suppression stops at the first non-zero.
        zero_run = 1'b1;
        lz_dark  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (act_data_q[i] == 4'd0);
            lz_dark[i] = bus.lz_en && zero_run && (i != 0);
        end

        dark    = act_blank_q[idx_q] || lz_dark[idx_q];
        anode_d = '1;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        if (!dark) begin
            anode_d[idx_q] = 1'b0;
            seg_d          = dec_seg;
            dp_d           = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            sh_data_q    <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            anode_q      <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sh_data_q    <= sh_data_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign bus.anode      = anode_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.pending    = pending_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected per-digit pin states are queued at load time
// and compared cycle by cycle over each displayed frame.
module tb_seg7_scan_driver;
    localparam int ND = 4;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [11:0] sb_q [$];
    logic [6:0]  codes [16];

    initial codes = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {anode, seg, dp} expected while digit i is being scanned
    function automatic logic [11:0] model(input logic [15:0] d, input logic [3:0] dpv,
                                          input logic [3:0] blk, input logic lz, input int i);
        logic       zero;
        logic [3:0] an;
        zero = 1'b1;
        for (int j = i; j < ND; j++) if (d[4*j +: 4] != 4'd0) zero = 1'b0;
        if (blk[i] || (lz && zero && i != 0)) return 12'hFFF;
        an    = 4'hF;
        an[i] = 1'b0;
        return {an, codes[d[4*i +: 4]], ~dpv[i]};
    endfunction

    task automatic push_frame(input logic [15:0] d, input logic [3:0] dpv,
                              input logic [3:0] blk, input logic lz);
        for (int i = 0; i < ND; i++) sb_q.push_back(model(d, dpv, blk, lz, i));
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] blk);
        bus.data_in  = d;
        bus.dp_in    = dpv;
        bus.blank_in = blk;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (bus.frame_tick !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("tick_wait", {31'd0, bus.frame_tick}, 32'd1);
    endtask

    // Entered at the negedge where frame_tick is seen; leaves at the next such negedge.
    task automatic check_frame(input string tag);
        logic [11:0] exp;
        for (int d = 0; d < ND; d++) begin
            if (sb_q.size() == 0) begin
                chk($sformatf("%s_sb_empty", tag), 32'd0, 32'd1);
                exp = 12'h000;
            end else begin
                exp = sb_q.pop_front();
            end
            for (int c = 0; c < RD; c++) begin
                @(negedge clk);
                chk($sformatf("%s_d%0d_c%0d", tag, d, c), {20'd0, bus.anode, bus.seg, bus.dp},
                    {20'd0, exp});
            end
        end
        chk({tag, "_period"}, {31'd0, bus.frame_tick}, 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        bus.data_in  = '0;
        bus.dp_in    = '0;
        bus.blank_in = '0;
        bus.lz_en    = 1'b0;
        bus.load     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset asserted mid-scan with a pending load, sampled before any clock edge
        do_load(16'hABCD, 4'hF, 4'h0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_anode", {28'd0, bus.anode}, 32'hF);
        chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
        chk("rst_dp", {31'd0, bus.dp}, 32'd1);
        chk("rst_pending", {31'd0, bus.pending}, 32'd0);
        chk("rst_tick", {31'd0, bus.frame_tick}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // plain hex frame
        do_load(16'h12AF, 4'h0, 4'h0);
        chk("t2_pending_set", {31'd0, bus.pending}, 32'd1);
        push_frame(16'h12AF, 4'h0, 4'h0, 1'b0);
        wait_tick();
        chk("t2_pending_clr", {31'd0, bus.pending}, 32'd0);
        check_frame("t2");
        @(negedge clk);
        chk("t2_tick_pulse", {31'd0, bus.frame_tick}, 32'd0);

        // leading-zero suppression
        bus.lz_en = 1'b1;
        do_load(16'h0050, 4'h0, 4'h0);
        push_frame(16'h0050, 4'h0, 4'h0, 1'b1);
        wait_tick();
        check_frame("t3a");
        do_load(16'h0000, 4'h0, 4'h0);
        push_frame(16'h0000, 4'h0, 4'h0, 1'b1);
        wait_tick();
        check_frame("t3b");

        // two loads in one frame: only the last is ever shown
        bus.lz_en = 1'b0;
        do_load(16'h1111, 4'h0, 4'h0);
        chk("t4_pending1", {31'd0, bus.pending}, 32'd1);
        repeat (3) @(negedge clk);
        do_load(16'h2222, 4'h0, 4'h0);
        chk("t4_pending2", {31'd0, bus.pending}, 32'd1);
        push_frame(16'h2222, 4'h0, 4'h0, 1'b0);
        wait_tick();
        chk("t4_pending_clr", {31'd0, bus.pending}, 32'd0);
        check_frame("t4");

        // load on the wrap clock goes straight to the display
        repeat (15) @(negedge clk);
        bus.data_in = 16'h5A3C;
        bus.load    = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        chk("t5_tick", {31'd0, bus.frame_tick}, 32'd1);
        chk("t5_pending", {31'd0, bus.pending}, 32'd0);
        push_frame(16'h5A3C, 4'h0, 4'h0, 1'b0);
        check_frame("t5");

        // blanking and decimal point
        do_load(16'h8888, 4'b0001, 4'b0100);
        push_frame(16'h8888, 4'b0001, 4'b0100, 1'b0);
        wait_tick();
        check_frame("t6");

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
